// File: rtl/lut3_cfg_writer_pkg.sv
// Shared definitions for the reconfigurable 3-input LUT writer.
package lut3_cfg_writer_pkg;
  localparam int TBL_W = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;
endpackage

// File: rtl/lut3_srl8.sv
// 8-bit shift register holding the LUT truth table: MSB-first serial load,
// 3-bit read mux for the lookup, top bit as the cascade output.
module lut3_srl8
  import lut3_cfg_writer_pkg::*;
#(
  parameter logic [TBL_W-1:0] INIT = '0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ce,
  input  logic       din,
  input  logic [2:0] sel,
  output logic       q,
  output logic       sout
);

  logic [TBL_W-1:0] sr;

  // Shift one bit in at the LSB when enabled; clear restores the initial table.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr <= INIT;
    end else if (ce) begin
      sr <= {sr[TBL_W-2:0], din};
    end
  end

  assign q    = sr[sel];
  assign sout = sr[TBL_W-1];

endmodule

// File: rtl/lut3_cfg_writer.sv
// LUT3 with a serial configuration writer. A new truth table is accepted in
// IDLE, then shifted MSB first into the table register over SHIFT_LEN enabled
// cycles, followed by a single FIN cycle that pulses DONE.
//
// Handshake: a table is taken on a rising edge where WR_VALID and WR_READY are
// both high and CLR is low. WR_READY is high only in IDLE; WR_VALID while busy
// is ignored and the offered data stays with the producer.
module lut3_cfg_writer
  import lut3_cfg_writer_pkg::*;
#(
  parameter logic [TBL_W-1:0] INIT      = 8'h00,
  parameter int               SHIFT_LEN = 8
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic [TBL_W-1:0] WR_DATA,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic             I0,
  input  logic             I1,
  input  logic             I2,
  output logic             O,
  output logic             LO,
  output logic             CDO,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       dbg_state
);

  // Counter value on the final shift; the wrap back to 0 happens on that edge.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHIFT_LEN - 1);

  state_t           state, state_n;
  logic [TBL_W-1:0] stg, stg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             shift_en;
  logic             lut_q;

  // Control state, staging word and shift counter.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      stg   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      stg   <= stg_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: accept in IDLE, shift while CE is high, one FIN cycle.
  always_comb begin
    state_n  = state;
    stg_n    = stg;
    cnt_n    = cnt;
    shift_en = 1'b0;
    DONE     = 1'b0;
    case (state)
      IDLE: begin
        if (WR_VALID) begin
          stg_n   = WR_DATA;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (CE) begin
          shift_en = 1'b1;
          stg_n    = {stg[TBL_W-2:0], 1'b0};
          cnt_n    = cnt + 1'b1;
          if (cnt == LAST) begin
            state_n = FIN;
          end
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  lut3_srl8 #(
    .INIT (INIT)
  ) u_srl (
    .clk  (C),
    .clr  (CLR),
    .ce   (shift_en),
    .din  (stg[TBL_W-1]),
    .sel  ({I2, I1, I0}),
    .q    (lut_q),
    .sout (CDO)
  );

  assign O         = lut_q;
  assign LO        = lut_q;
  assign BUSY      = (state != IDLE);
  assign WR_READY  = ~BUSY;
  assign dbg_state = state;

endmodule

// File: tb/tb_lut3_cfg_writer.sv
// Bench for lut3_cfg_writer: directed scenarios followed by random traffic,
// all compared against a table-level reference model.
module tb_lut3_cfg_writer;

  localparam logic [7:0] INIT_V = 8'hE8;

  logic       C = 1'b0;
  logic       CLR, CE, WR_VALID, I0, I1, I2;
  logic [7:0] WR_DATA;
  logic       WR_READY, O, LO, CDO, BUSY, DONE;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the table is tracked as a whole word; mid-load contents
  // are the old table shifted left by k with the top k bits of the new word.
  logic [7:0] m_tbl, m_old, m_word;
  bit         m_busy;
  int         m_k;

  lut3_cfg_writer #(
    .INIT      (INIT_V),
    .SHIFT_LEN (8)
  ) dut (
    .C         (C),
    .CLR       (CLR),
    .CE        (CE),
    .WR_DATA   (WR_DATA),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .I0        (I0),
    .I1        (I1),
    .I2        (I2),
    .O         (O),
    .LO        (LO),
    .CDO       (CDO),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 C = ~C;

  function automatic logic [7:0] tbl_after(input logic [7:0] old, input logic [7:0] word, input int k);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = {8'h00, old} << k;
    lo = {8'h00, word} >> (8 - k);
    return 8'(hi | lo);
  endfunction

  task automatic model_reset();
    m_tbl  = INIT_V;
    m_busy = 1'b0;
    m_k    = 0;
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    if (CLR) begin
      model_reset();
    end else if (!m_busy) begin
      if (WR_VALID) begin
        m_busy = 1'b1;
        m_word = WR_DATA;
        m_old  = m_tbl;
        m_k    = 0;
      end
    end else if (m_k < 8) begin
      if (CE) begin
        m_k   = m_k + 1;
        m_tbl = tbl_after(m_old, m_word, m_k);
      end
    end else begin
      m_busy = 1'b0;
      m_k    = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0] exp_st;
    logic [2:0] sel;
    sel    = {I2, I1, I0};
    exp_st = !m_busy ? 2'd0 : ((m_k < 8) ? 2'd1 : 2'd2);
    chk({tag, "_ready"}, {7'd0, WR_READY}, {7'd0, !m_busy});
    chk({tag, "_busy"},  {7'd0, BUSY},     {7'd0, m_busy});
    chk({tag, "_done"},  {7'd0, DONE},     {7'd0, (m_busy && m_k == 8)});
    chk({tag, "_cdo"},   {7'd0, CDO},      {7'd0, m_tbl[7]});
    chk({tag, "_o"},     {7'd0, O},        {7'd0, m_tbl[sel]});
    chk({tag, "_lo"},    {7'd0, LO},       {7'd0, m_tbl[sel]});
    chk({tag, "_state"}, {6'd0, dbg_state}, {6'd0, exp_st});
  endtask

  // One clock cycle: drive inputs, take the edge, check 1 ns later.
  task automatic step(input logic ce, input logic valid, input logic [7:0] data);
    CE       = ce;
    WR_VALID = valid;
    WR_DATA  = data;
    {I2, I1, I0} = 3'($urandom_range(0, 7));
    @(posedge C);
    model_edge();
    #1;
    check_outputs("step");
  endtask

  // Walk all eight select codes and compare O against an expected table.
  task automatic sweep(input string tag, input logic [7:0] exp_tbl);
    logic [7:0] t;
    t = exp_tbl;
    for (int s = 0; s < 8; s++) begin
      {I2, I1, I0} = 3'(s);
      #1;
      chk(tag, {7'd0, O}, {7'd0, t[s]});
    end
  endtask

  // Asynchronous clear raised between edges, held over one edge.
  task automatic do_clr();
    #2;
    CLR      = 1'b1;
    WR_VALID = 1'($urandom_range(0, 1));
    WR_DATA  = 8'($urandom_range(0, 255));
    model_reset();
    #1;
    check_outputs("clr_async");
    @(posedge C);
    model_edge();
    #1;
    check_outputs("clr_edge");
    CLR      = 1'b0;
    WR_VALID = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    // Reset block
    CLR = 1'b1; CE = 1'b0; WR_VALID = 1'b0; WR_DATA = 8'h00;
    {I2, I1, I0} = 3'b110;
    model_reset();
    #2;
    chk("rst_o",     {7'd0, O},        8'd1);
    chk("rst_lo",    {7'd0, LO},       8'd1);
    chk("rst_cdo",   {7'd0, CDO},      8'd1);
    chk("rst_ready", {7'd0, WR_READY}, 8'd1);
    chk("rst_busy",  {7'd0, BUSY},     8'd0);
    chk("rst_done",  {7'd0, DONE},     8'd0);
    @(posedge C);
    #1;
    check_outputs("rst");
    CLR = 1'b0;

    // Load 0x96 with CE held high: busy 9 cycles, DONE in the 10th cycle.
    step(1'b1, 1'b1, 8'h96);
    busy_cnt = BUSY ? 1 : 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    chk("p96_busy_cycles", 8'(busy_cnt), 8'd9);
    chk("p96_done_pulses", 8'(done_cnt), 8'd1);
    chk("p96_done_pos",    8'(done_at),  8'd8);
    for (int s = 0; s < 8; s++) begin
      {I2, I1, I0} = 3'(s);
      #1;
      chk("p96_parity", {7'd0, O}, {7'd0, ^(3'(s))});
    end

    // Load 0xFF with CE toggling, low on the first shift cycle.
    step(1'b1, 1'b1, 8'hFF);
    done_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step((i % 2) == 0, 1'b0, 8'h00);
      if (DONE && done_at < 0) done_at = i;
    end
    chk("pff_done_pos", 8'(done_at), 8'd16);
    sweep("pff_table", 8'hFF);

    // Load 0x01, abort with clear after four shifts.
    step(1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
    do_clr();
    chk("abort_busy",  {7'd0, BUSY},     8'd0);
    chk("abort_ready", {7'd0, WR_READY}, 8'd1);
    sweep("abort_table", INIT_V);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00);

    // WR_VALID held: 0xAA taken, 0x55 ignored while busy, taken once idle.
    step(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h55);
    chk("hold_done", {7'd0, DONE}, 8'd1);
    sweep("hold_aa", 8'hAA);
    step(1'b1, 1'b1, 8'h55);
    chk("hold_idle_ready", {7'd0, WR_READY}, 8'd1);
    step(1'b1, 1'b1, 8'h55);
    chk("hold_55_busy", {7'd0, BUSY}, 8'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h00);
    sweep("hold_55", 8'h55);

    // From an all-zero table, load 0xA5 and watch the cascade bit.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00);
    sweep("zero_table", 8'h00);
    step(1'b1, 1'b1, 8'hA5);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("a5_cdo", {7'd0, CDO}, (k == 8) ? 8'd1 : 8'd0);
    end
    step(1'b1, 1'b0, 8'h00);
    sweep("a5_table", 8'hA5);

    // Random traffic with occasional asynchronous clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_clr();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lut3_cfg_writer.md
LUT3_CFG_WRITER -- requirements
Module: lut3_cfg_writer

Interface
REQ-001 SHALL have parameter INIT, default 8'h00, meaning the truth table loaded at clear.
REQ-002 SHALL have parameter SHIFT_LEN, default 8, meaning the number of shift cycles per load; fixed at 8, other values unsupported.
REQ-003 SHALL have port C  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port CLR  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port CE  input  1  shift enable; low stalls an in-progress load.
REQ-006 SHALL have port WR_DATA  input  8  new truth table, bit n = output for {I2,I1,I0}=n.
REQ-007 SHALL have port WR_VALID  input  1  WR_DATA valid.
REQ-008 SHALL have port WR_READY  output  1  writer can accept a table.
REQ-009 SHALL have ports I0, I1, I2  input  1 each  LUT select inputs.
REQ-010 SHALL have ports O, LO  output  1 each  combinational lookup of current table; identical values.
REQ-011 SHALL have port CDO  output  1  serial cascade out, table bit 7.
REQ-012 SHALL have port BUSY  output  1  load in progress.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse, load complete.

Function
REQ-014 SHALL hold an 8-bit table register TBL, an 8-bit staging register STG, a 3-bit counter CNT, and state in {IDLE, SHIFT, FIN}.
REQ-015 SHALL drive O = LO = TBL[{I2,I1,I0}] combinationally at all times, including mid-load.
REQ-016 SHALL drive CDO = TBL[7].
REQ-017 SHALL assert WR_READY only in IDLE; handshake = WR_VALID & WR_READY at a rising edge.
REQ-018 On handshake SHALL capture STG <= WR_DATA, CNT <= 0, go SHIFT; TBL unchanged that edge.
REQ-019 In SHIFT with CE=1 SHALL do TBL <= {TBL[6:0], STG[7]}, STG <= {STG[6:0],1'b0}, CNT <= CNT+1 (MSB first).
REQ-020 In SHIFT with CE=0 SHALL hold TBL, STG, CNT and state.
REQ-021 On the shift edge where CNT==7 SHALL go FIN; TBL then equals captured WR_DATA.
REQ-022 In FIN SHALL assert DONE for exactly one cycle, then return to IDLE unconditionally (CE ignored).
REQ-023 BUSY SHALL be 1 in SHIFT and FIN, 0 in IDLE; WR_READY = ~BUSY.
REQ-024 Minimum load-to-load period SHALL be 10 cycles (1 accept + 8 shift + 1 FIN), with CE held 1.
REQ-025 WR_VALID asserted while BUSY SHALL be ignored; no data captured or lost from internal state.
REQ-026 CNT wrap 7->0 SHALL coincide only with SHIFT->FIN; no other wrap permitted.

Reset
REQ-027 CLR=1 SHALL immediately force TBL=INIT, STG=0, CNT=0, state IDLE, regardless of C.
REQ-028 During CLR outputs SHALL be: WR_READY=1, BUSY=0, DONE=0, CDO=INIT[7], O=LO=INIT[{I2,I1,I0}].
REQ-029 CLR mid-load SHALL abort the load; partially shifted table discarded, TBL=INIT.
REQ-030 No handshake SHALL complete on an edge where CLR=1.

Structure
REQ-031 Shared package SHALL hold state encodings (IDLE=2'd0, SHIFT=2'd1, FIN=2'd2) and table width constant 8.
REQ-032 SHALL instantiate one sub-module lut3_srl8: 8-bit shift register with CE, async CLR to INIT, 3-bit read mux, serial out.
REQ-033 Control FSM, STG and CNT SHALL live in the top level.

Verification
REQ-034 CLR pulse with INIT=8'hE8, I={1,1,0} -> O=LO=1, CDO=1, WR_READY=1, BUSY=0.
REQ-035 Load 8'h96, CE=1 -> BUSY 9 cycles, DONE single pulse on cycle 10, then exhaustive I sweep gives O=parity(I).
REQ-036 Load 8'hFF with CE toggling 1/0 each cycle -> 8 effective shifts, DONE 17 cycles after handshake, TBL=8'hFF.
REQ-037 Load 8'h01, CLR asserted after 4 shifts -> TBL=INIT immediately, IDLE, no DONE.
REQ-038 WR_VALID held high with 8'hAA then 8'h55 during BUSY -> only 8'hAA loaded; 8'h55 accepted on next IDLE cycle.
REQ-039 Load 8'hA5 from TBL=8'h00 -> CDO sequence over shift edges = 0,0,0,0,0,0,0,0 then TBL[7]=1 after last shift.
